// File: rtl/iomem_led_pwm.sv
// Two-channel LED PWM controller on the PicoSoC iomem bus with double-buffered duty.
// Optional wrap interrupt: define LED_PWM_IRQ_EN to build irq and CTRL.IRQEN.
module iomem_led_pwm #(
    parameter logic [7:0]  ADDR_HI        = 8'h04,
    parameter logic [15:0] PRESCALE_RESET = 16'd99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [1:0]  led,
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_DUTY0    = 3'd2;
    localparam logic [2:0] OFF_DUTY1    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  led_q, led_d;
    logic [1:0]  en_q, en_d;
    logic        inv_q, inv_d;
    logic [15:0] prescale_q, prescale_d;
    logic [7:0]  duty0_q, duty0_d;
    logic [7:0]  duty1_q, duty1_d;
    logic [7:0]  act0_q, act0_d;
    logic [7:0]  act1_q, act1_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic        wrap_flag_q, wrap_flag_d;

    logic        sel_s;
    logic        wr_s;
    logic [2:0]  off_s;
    logic        wr_ctrl_s;
    logic        wr_pre_s;
    logic        wr_duty0_s;
    logic        wr_duty1_s;
    logic        wr_status_s;
    logic        pre_touch_s;
    logic        w1c_s;
    logic        tick_s;
    logic        wrap_s;
    logic        irqen_s;
    logic [31:0] rd_data_s;
    logic        unused_s;

    assign sel_s       = iomem_valid & ~ready_q & (iomem_addr[31:24] == ADDR_HI);
    assign wr_s        = sel_s & (iomem_wstrb != 4'b0000);
    assign off_s       = iomem_addr[4:2];
    assign wr_ctrl_s   = wr_s & (off_s == OFF_CTRL);
    assign wr_pre_s    = wr_s & (off_s == OFF_PRESCALE);
    assign wr_duty0_s  = wr_s & (off_s == OFF_DUTY0);
    assign wr_duty1_s  = wr_s & (off_s == OFF_DUTY1);
    assign wr_status_s = wr_s & (off_s == OFF_STATUS);
    assign pre_touch_s = wr_pre_s & (iomem_wstrb[1] | iomem_wstrb[0]);
    assign w1c_s       = wr_status_s & iomem_wstrb[0] & iomem_wdata[0];

    assign tick_s = (pre_cnt_q == prescale_q);
    assign wrap_s = tick_s & (pwm_cnt_q == 8'd255);

    assign unused_s = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata[31:16], iomem_wstrb[3:2]};

`ifdef LED_PWM_IRQ_EN
    logic irqen_q, irqen_d;
    logic irq_q, irq_d;

    // IRQ enable bit and registered level interrupt
    always_comb begin
        irqen_d = irqen_q;
        irq_d   = wrap_flag_q & irqen_q;
        if (wr_ctrl_s && iomem_wstrb[1]) begin
            irqen_d = iomem_wdata[9];
        end else begin
            irqen_d = irqen_q;
        end
    end

    // IRQ state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end

    assign irqen_s = irqen_q;
    assign irq     = irq_q;
`else
    assign irqen_s = 1'b0;
    assign irq     = 1'b0;
`endif

    // Register read mux; returns pre-write values of the addressed register
    always_comb begin
        rd_data_s = 32'd0;
        case (off_s)
            OFF_CTRL:     rd_data_s = {22'd0, irqen_s, inv_q, 6'd0, en_q};
            OFF_PRESCALE: rd_data_s = {16'd0, prescale_q};
            OFF_DUTY0:    rd_data_s = {24'd0, duty0_q};
            OFF_DUTY1:    rd_data_s = {24'd0, duty1_q};
            OFF_STATUS:   rd_data_s = {16'd0, pwm_cnt_q, 7'd0, wrap_flag_q};
            default:      rd_data_s = 32'd0;
        endcase
    end

    // Next-state logic for bus, registers, counters and LED outputs
    always_comb begin
        ready_d     = sel_s;
        rdata_d     = rdata_q;
        en_d        = en_q;
        inv_d       = inv_q;
        prescale_d  = prescale_q;
        duty0_d     = duty0_q;
        duty1_d     = duty1_q;
        act0_d      = act0_q;
        act1_d      = act1_q;
        pre_cnt_d   = pre_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        wrap_flag_d = wrap_flag_q;

        if (sel_s) begin
            rdata_d = rd_data_s;
        end else begin
            rdata_d = rdata_q;
        end

        en_d  = (wr_ctrl_s & iomem_wstrb[0]) ? iomem_wdata[1:0] : en_q;
        inv_d = (wr_ctrl_s & iomem_wstrb[1]) ? iomem_wdata[8]   : inv_q;

        prescale_d[7:0]  = (wr_pre_s & iomem_wstrb[0]) ? iomem_wdata[7:0]  : prescale_q[7:0];
        prescale_d[15:8] = (wr_pre_s & iomem_wstrb[1]) ? iomem_wdata[15:8] : prescale_q[15:8];

        duty0_d = (wr_duty0_s & iomem_wstrb[0]) ? iomem_wdata[7:0] : duty0_q;
        duty1_d = (wr_duty1_s & iomem_wstrb[0]) ? iomem_wdata[7:0] : duty1_q;

        // A prescale write restarts the divider so the new period starts cleanly
        if (pre_touch_s) begin
            pre_cnt_d = 16'd0;
        end else if (tick_s) begin
            pre_cnt_d = 16'd0;
        end else begin
            pre_cnt_d = pre_cnt_q + 16'd1;
        end

        if (tick_s) begin
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end else begin
            pwm_cnt_d = pwm_cnt_q;
        end

        if (wrap_s) begin
            act0_d = duty0_q;
            act1_d = duty1_q;
        end else begin
            act0_d = act0_q;
            act1_d = act1_q;
        end

        // Setting the sticky flag takes priority over a simultaneous clear
        if (wrap_s) begin
            wrap_flag_d = 1'b1;
        end else if (w1c_s) begin
            wrap_flag_d = 1'b0;
        end else begin
            wrap_flag_d = wrap_flag_q;
        end

        led_d[0] = (en_q[0] & (pwm_cnt_q < act0_q)) ^ inv_q;
        led_d[1] = (en_q[1] & (pwm_cnt_q < act1_q)) ^ inv_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
            led_q       <= 2'b00;
            en_q        <= 2'b00;
            inv_q       <= 1'b0;
            prescale_q  <= PRESCALE_RESET;
            duty0_q     <= 8'd0;
            duty1_q     <= 8'd0;
            act0_q      <= 8'd0;
            act1_q      <= 8'd0;
            pre_cnt_q   <= 16'd0;
            pwm_cnt_q   <= 8'd0;
            wrap_flag_q <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            led_q       <= led_d;
            en_q        <= en_d;
            inv_q       <= inv_d;
            prescale_q  <= prescale_d;
            duty0_q     <= duty0_d;
            duty1_q     <= duty1_d;
            act0_q      <= act0_d;
            act1_q      <= act1_d;
            pre_cnt_q   <= pre_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            wrap_flag_q <= wrap_flag_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign led         = led_q;

endmodule

// File: tb/tb_iomem_led_pwm.sv
// Self-checking bench for iomem_led_pwm: register table, directed PWM/W1C/IRQ
// sequences and random bus traffic against a phase-based reference model.
module tb_iomem_led_pwm;

    logic        clk;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [1:0]  led;
    logic        irq;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int gprint = 0;
    bit chk_en = 0;
    logic prev0 = 1'b0;
    int edges[$];

`ifdef LED_PWM_IRQ_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_0303;
    localparam logic [31:0] CTRL_B0  = 32'h0000_0302;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_0103;
    localparam logic [31:0] CTRL_B0  = 32'h0000_0102;
`endif

    iomem_led_pwm #(.ADDR_HI(8'h04), .PRESCALE_RESET(16'd99)) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .led(led), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the position inside the PWM period is one integer phase
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [1:0]  m_led;
    logic        m_irq;
    logic [1:0]  m_en;
    logic        m_inv;
    logic        m_irqen;
    int          m_pre;
    logic [7:0]  m_duty [2];
    logic [7:0]  m_act [2];
    int          m_phase;
    logic        m_wrapf;

    function automatic int model_pwm();
        return m_phase / (m_pre + 1);
    endfunction

    always @(posedge clk) begin : model
        int p1, pwm, pre, npwm;
        bit tick, wrap, sel, wr;
        logic [2:0] off;
        logic [31:0] rv;
        logic [15:0] np;
        if (reset) begin
            m_ready <= 1'b0; m_rdata <= 32'd0; m_led <= 2'b00; m_irq <= 1'b0;
            m_en <= 2'b00; m_inv <= 1'b0; m_irqen <= 1'b0; m_pre <= 99;
            m_duty[0] <= 8'd0; m_duty[1] <= 8'd0; m_act[0] <= 8'd0; m_act[1] <= 8'd0;
            m_phase <= 0; m_wrapf <= 1'b0;
        end else begin
            p1   = m_pre + 1;
            pwm  = m_phase / p1;
            pre  = m_phase % p1;
            tick = (pre == m_pre);
            wrap = tick && (pwm == 255);
            sel  = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h04);
            wr   = sel && (iomem_wstrb != 4'd0);
            off  = iomem_addr[4:2];
            rv   = 32'd0;
            case (off)
                3'd0: begin rv[1:0] = m_en; rv[8] = m_inv; rv[9] = m_irqen; end
                3'd1: rv[15:0] = m_pre[15:0];
                3'd2: rv[7:0] = m_duty[0];
                3'd3: rv[7:0] = m_duty[1];
                3'd4: begin rv[0] = m_wrapf; rv[15:8] = pwm[7:0]; end
                default: rv = 32'd0;
            endcase
            m_ready <= sel;
            if (sel) m_rdata <= rv;
            m_led[0] <= ((m_en[0] && (pwm < int'(m_act[0]))) ? 1'b1 : 1'b0) ^ m_inv;
            m_led[1] <= ((m_en[1] && (pwm < int'(m_act[1]))) ? 1'b1 : 1'b0) ^ m_inv;
`ifdef LED_PWM_IRQ_EN
            m_irq <= m_wrapf & m_irqen;
`else
            m_irq <= 1'b0;
`endif
            if (wrap) begin
                m_act[0] <= m_duty[0];
                m_act[1] <= m_duty[1];
            end
            if (wrap) m_wrapf <= 1'b1;
            else if (wr && off == 3'd4 && iomem_wstrb[0] && iomem_wdata[0]) m_wrapf <= 1'b0;
            if (wr && off == 3'd0 && iomem_wstrb[0]) m_en <= iomem_wdata[1:0];
            if (wr && off == 3'd0 && iomem_wstrb[1]) begin
                m_inv <= iomem_wdata[8];
`ifdef LED_PWM_IRQ_EN
                m_irqen <= iomem_wdata[9];
`endif
            end
            if (wr && off == 3'd2 && iomem_wstrb[0]) m_duty[0] <= iomem_wdata[7:0];
            if (wr && off == 3'd3 && iomem_wstrb[0]) m_duty[1] <= iomem_wdata[7:0];
            if (wr && off == 3'd1 && (iomem_wstrb[0] || iomem_wstrb[1])) begin
                np = m_pre[15:0];
                if (iomem_wstrb[0]) np[7:0] = iomem_wdata[7:0];
                if (iomem_wstrb[1]) np[15:8] = iomem_wdata[15:8];
                npwm = (pwm + (tick ? 1 : 0)) % 256;
                m_pre   <= int'(np);
                m_phase <= npwm * (int'(np) + 1);
            end else begin
                m_phase <= (m_phase + 1) % (256 * p1);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus led[0] edge log
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (iomem_ready !== m_ready || led !== m_led || irq !== m_irq ||
                (m_ready && iomem_rdata !== m_rdata)) begin
                fails++;
                if (gprint < 20) begin
                    gprint++;
                    $display("FAIL model cycle %0d: ready %b/%b led %b/%b irq %b/%b rdata %h/%h (got/expected)",
                             cyc, iomem_ready, m_ready, led, m_led, irq, m_irq, iomem_rdata, m_rdata);
                end
            end
        end
        if (led[0] !== prev0) edges.push_back(cyc);
        prev0 = led[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [2:0] off, input logic [31:0] wd, input logic [3:0] st,
                       input bit now, output logic [31:0] rd);
        if (!now) begin
            @(posedge clk); #1;
        end
        iomem_valid = 1'b1;
        iomem_addr  = {8'h04, 19'd0, off, 2'b00};
        iomem_wdata = wd;
        iomem_wstrb = st;
        @(posedge clk); #1;
        check("ack", {31'd0, iomem_ready}, 32'd1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  off;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[$];
        logic [31:0] rd;
        logic [31:0] r;
        int n, bad;

        reset = 1'b1; iomem_valid = 1'b0; iomem_addr = 32'd0;
        iomem_wdata = 32'd0; iomem_wstrb = 4'd0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_led", {30'd0, led}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // offset, wdata, wstrb, expected read (reads only)
        tbl.push_back('{3'd0, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{3'd1, 32'h0, 4'h0, 32'd99});
        tbl.push_back('{3'd2, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{3'd3, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{3'd4, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{3'd7, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{3'd0, 32'hFFFF_FFFF, 4'hF, 32'h0});
        tbl.push_back('{3'd0, 32'h0, 4'h0, CTRL_ALL});
        tbl.push_back('{3'd0, 32'h0000_0002, 4'h1, 32'h0});
        tbl.push_back('{3'd0, 32'h0, 4'h0, CTRL_B0});
        tbl.push_back('{3'd1, 32'hABCD_1234, 4'h3, 32'h0});
        tbl.push_back('{3'd1, 32'h0, 4'h0, 32'h0000_1234});
        tbl.push_back('{3'd1, 32'h0000_5600, 4'h2, 32'h0});
        tbl.push_back('{3'd1, 32'h0, 4'h0, 32'h0000_5634});
        tbl.push_back('{3'd2, 32'h0000_01FF, 4'hF, 32'h0});
        tbl.push_back('{3'd2, 32'h0, 4'h0, 32'h0000_00FF});
        tbl.push_back('{3'd3, 32'h0000_AA55, 4'h2, 32'h0});
        tbl.push_back('{3'd3, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0});
        tbl.push_back('{3'd6, 32'h0, 4'h0, 32'h0});
        foreach (tbl[i]) begin
            bus(tbl[i].off, tbl[i].wd, tbl[i].st, 1'b0, rd);
            if (tbl[i].st == 4'd0) check($sformatf("reg_rd%0d", i), rd, tbl[i].exp);
        end

        // Foreign address window: never acknowledged, no state change
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wdata = 32'd0; iomem_wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("foreign_ack", {31'd0, iomem_ready}, 32'd0);
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        bus(3'd0, 32'd0, 4'd0, 1'b0, rd);
        check("foreign_nowrite", rd, CTRL_B0);

        // Reset during a pending request aborts the ack
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'd0; reset = 1'b1;
        @(posedge clk); #1;
        check("rst_abort_ready", {31'd0, iomem_ready}, 32'd0);
        iomem_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // PWM waveform with duty 64, then a mid-period update to 200
        do_reset();
        bus(3'd1, 32'd0, 4'h3, 1'b0, rd);
        bus(3'd2, 32'd64, 4'h1, 1'b0, rd);
        bus(3'd0, 32'h1, 4'h1, 1'b0, rd);
        edges.delete();
        n = 0; bad = 0;
        while (edges.size() < 1 && n < 2000) begin
            @(posedge clk); #1; n++;
            if (led[1] !== 1'b0) bad++;
        end
        bus(3'd2, 32'd200, 4'h1, 1'b0, rd);
        while (edges.size() < 5 && n < 4000) begin
            @(posedge clk); #1; n++;
            if (led[1] !== 1'b0) bad++;
        end
        check("led1_off", bad, 32'd0);
        if (edges.size() >= 5) begin
            check("high64", edges[1] - edges[0], 32'd64);
            check("low192", edges[2] - edges[1], 32'd192);
            check("period256", edges[2] - edges[0], 32'd256);
            check("high200", edges[3] - edges[2], 32'd200);
            check("low56", edges[4] - edges[3], 32'd56);
        end else begin
            check("pwm_edge_timeout", edges.size(), 32'd5);
        end

        // Inversion with disabled channels, then enabled with duty 0
        do_reset();
        bus(3'd0, 32'h100, 4'h2, 1'b0, rd);
        wait_cycles(2);
        check("inv_disabled", {30'd0, led}, 32'd3);
        bus(3'd1, 32'd0, 4'h3, 1'b0, rd);
        bus(3'd0, 32'h103, 4'h3, 1'b0, rd);
        wait_cycles(2);
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            if (led[1] !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check("inv_duty0_led1", bad, 32'd0);

        // W1C on the exact wrap edge: set wins; later W1C clears
        do_reset();
        bus(3'd1, 32'd0, 4'h3, 1'b0, rd);
        n = 0;
        while (model_pwm() != 255 && n < 600) begin
            @(posedge clk); #1; n++;
        end
        check("w1c_sync", {31'd0, n < 600}, 32'd1);
        bus(3'd4, 32'd1, 4'h1, 1'b1, rd);
        bus(3'd4, 32'd0, 4'h0, 1'b0, rd);
        check("w1c_set_wins", {31'd0, rd[0]}, 32'd1);
        bus(3'd4, 32'd1, 4'h1, 1'b0, rd);
        bus(3'd4, 32'd0, 4'h0, 1'b0, rd);
        check("w1c_clear", {31'd0, rd[0]}, 32'd0);

        // Interrupt behaviour
        do_reset();
        bus(3'd1, 32'd0, 4'h3, 1'b0, rd);
`ifdef LED_PWM_IRQ_EN
        bus(3'd0, 32'h201, 4'h3, 1'b0, rd);
        n = 0;
        while (irq !== 1'b1 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        check("irq_rise", {31'd0, irq}, 32'd1);
        bus(3'd4, 32'd1, 4'h1, 1'b1, rd);
        check("irq_hold", {31'd0, irq}, 32'd1);
        wait_cycles(1);
        check("irq_fall", {31'd0, irq}, 32'd0);
`else
        bus(3'd0, 32'h201, 4'h3, 1'b0, rd);
        bus(3'd0, 32'd0, 4'h0, 1'b0, rd);
        check("ctrl_no_irqen", rd, 32'h0000_0001);
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            if (irq !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("irq_tied_low", bad, 32'd0);
`endif

        // Random traffic, checked cycle by cycle against the model
        do_reset();
        r = $urandom;
        bus(3'd1, {31'd0, r[0]}, 4'h3, 1'b0, rd);
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                logic [2:0]  off;
                logic [3:0]  st;
                logic [31:0] wd;
                r = $urandom; off = r[2:0];
                r = $urandom; st = (r[5:4] == 2'd0) ? 4'd0 : r[3:0];
                wd = $urandom;
                if (off == 3'd1) begin
                    r = $urandom;
                    wd = {30'd0, r[1:0]};
                end
                bus(off, wd, st, 1'b0, rd);
            end else if (r == 6) begin
                @(posedge clk); #1;
                r = $urandom;
                iomem_valid = 1'b1; iomem_addr = {8'h04, 19'd0, r[2:0], 2'b00}; iomem_wstrb = 4'd0;
                wait_cycles(5);
                iomem_valid = 1'b0;
            end else if (r == 7) begin
                @(posedge clk); #1;
                iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wdata = $urandom; iomem_wstrb = 4'hF;
                wait_cycles(3);
                iomem_valid = 1'b0; iomem_wstrb = 4'd0;
            end else begin
                wait_cycles($urandom_range(1, 20));
            end
        end
        wait_cycles(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iomem_led_pwm.md
# iomem_led_pwm

Memory-mapped two-channel LED PWM controller on the PicoSoC `iomem` bus, occupying the address window next to the GPIO register at `0x03xxxxxx`. It replaces direct GPIO drive of `led[1:0]` with per-channel 8-bit duty control, a programmable tick prescaler, double-buffered duty updates and a sticky period-wrap flag. It consumes `iomem` transactions from the CPU and produces the board LED outputs.

## Interface
- `ADDR_HI`, default `8'h04`, value of `iomem_addr[31:24]` that selects this block.
- `PRESCALE_RESET`, default `16'd99`, reset value of the PRESCALE register.

- `clk`, input, 1, system clock; all logic is on the rising edge.
- `reset`, input, 1, synchronous, active-high reset.
- `iomem_valid`, input, 1, CPU bus request.
- `iomem_ready`, output, 1, one-cycle acknowledge.
- `iomem_wstrb`, input, 4, byte write strobes; `0000` means read.
- `iomem_addr`, input, 32, byte address.
- `iomem_wdata`, input, 32, write data.
- `iomem_rdata`, output, 32, read data, valid while `iomem_ready`=1.
- `led`, output, 2, PWM outputs, registered.
- `irq`, output, 1, wrap interrupt, level; see Configuration.

## Operation
- Selection: `sel = iomem_valid & !iomem_ready & (iomem_addr[31:24] == ADDR_HI)`. Register offset: `iomem_addr[4:2]`.
- Register map, with unlisted bits reading as 0:
  - 0x00 CTRL: [0] EN0, [1] EN1, [8] INV, [9] IRQEN.
  - 0x04 PRESCALE: [15:0].
  - 0x08 DUTY0: [7:0].
  - 0x0C DUTY1: [7:0].
  - 0x10 STATUS: [0] WRAP (sticky, write-1-to-clear), [15:8] current `pwm_cnt` (read-only).
- Offsets 0x14–0x1C: acknowledged normally, read 0, writes ignored.
- Writes honour `iomem_wstrb` per byte. Writes to read-only fields are ignored.
- Prescaler:
  - `pre_cnt` (16 bits) counts 0..PRESCALE.
  - `tick` = (`pre_cnt == PRESCALE`). On `tick`, `pre_cnt` returns to 0.
  - Any write touching PRESCALE bytes clears `pre_cnt` to 0 in the same cycle.
- PWM counter:
  - `pwm_cnt` (8 bits) increments on `tick` and wraps 255→0.
  - `wrap` = `tick & (pwm_cnt == 255)`.
- Duty double-buffering:
  - DUTY registers are shadows.
  - On `wrap`, `duty_act[i]` loads from DUTYi.
  - Writes between wraps have no effect on `led` until the next wrap.
- Output: `led[i] <= (ENi & (pwm_cnt < duty_act[i])) ^ INV`, evaluated every cycle.
  - Duty 0 gives always off; duty 255 gives on for 255 of 256 steps.
  - A disabled channel outputs INV.
- STATUS.WRAP is set on `wrap`. If `wrap` and a write-1-clear occur in the same cycle, set wins.

## Timing
- Bus handshake: `iomem_ready` is high exactly one cycle, the cycle after `sel`.
  - `iomem_rdata` is registered in the same edge and valid with `iomem_ready`.
  - The write takes effect on that same edge.
  - `iomem_ready` never asserts on back-to-back cycles. Because of the `!iomem_ready` term, a held `iomem_valid` gets a new ack every second cycle.
- Requests with other `iomem_addr[31:24]` values: no response, no state change.
- `led` lags `pwm_cnt` by one cycle (registered compare).
- Period of one PWM cycle: 256 × (PRESCALE+1) clocks. With PRESCALE=0, `pwm_cnt` advances every clock.
- Reset (synchronous; mid-operation reset aborts any pending ack) drives:
  - `iomem_ready`=0, `iomem_rdata`=0, `led`=0, `irq`=0.
  - CTRL=0, PRESCALE=`PRESCALE_RESET`, DUTY0/1=0, `duty_act`=0.
  - `pre_cnt`=0, `pwm_cnt`=0, WRAP=0.

## Configuration
- Macro: `LED_PWM_IRQ_EN`.
- Defined: `irq` is registered as `STATUS.WRAP & CTRL.IRQEN`, so it rises one cycle after WRAP sets. CTRL[9] is read/write.
- Undefined: `irq` is tied to 0, CTRL[9] reads 0 and ignores writes, and no IRQ logic is synthesised. The port list is identical in both builds.

## Test plan
- Reset, then read all five offsets: CTRL=0, PRESCALE=99, DUTY0=DUTY1=0, STATUS=0. Each ack arrives one cycle after valid and lasts one cycle.
- PRESCALE=0, DUTY0=64, CTRL=0x1; after the first wrap, `led[0]` is high 64 consecutive clocks and low 192, repeating every 256. `led[1]`=0 throughout.
- Write DUTY0=200 in mid-period: `led[0]` high-time stays 64 until the next wrap, then becomes 200.
- CTRL=0x100 (INV, channels disabled): `led`=2'b11. Then CTRL=0x103 with DUTY1=0: `led[1]`=1 constantly.
- Write STATUS=1 on the exact cycle `wrap` fires: WRAP reads back 1. A later write of 1 with no wrap reads back 0.
- With `LED_PWM_IRQ_EN`, CTRL=0x201 and PRESCALE=0: `irq` rises 1 cycle after WRAP sets and falls 1 cycle after the W1C. Without the macro, `irq` stays 0 and CTRL reads 0x001.
